pipe_csa_adder: RTL and testbench

PIPE_CSA_ADDER -- requirements
Module: pipe_csa_adder

---
 rtl/csa_pkg.sv | 7 +
 rtl/csa_block.sv | 34 +++
 rtl/pipe_csa_adder.sv | 101 ++++++++++
 tb/tb_pipe_csa_adder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared op encoding and default geometry for the pipelined carry-select adder
package csa_pkg;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_BLK   = 8;
endpackage

// File: rtl/csa_block.sv
// csa_block: BLK-bit adder with two ripple chains (carry-in 0 and 1); the
// incoming carry selects the precomputed sum and carry-out.
module csa_block
    import csa_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           op,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);
    logic [BLK-1:0] be, s0, s1;
    logic [BLK:0]   c0, c1;

    always_comb begin
        be = (op == OP_SUB) ? ~b : b;
        s0 = '0;
        s1 = '0;
        c0 = {{BLK{1'b0}}, 1'b0};
        c1 = {{BLK{1'b0}}, 1'b1};
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ be[i] ^ c0[i];
            c0[i+1] = (a[i] & be[i]) | (c0[i] & (a[i] ^ be[i]));
            s1[i]   = a[i] ^ be[i] ^ c1[i];
            c1[i+1] = (a[i] & be[i]) | (c1[i] & (a[i] ^ be[i]));
        end
    end

    assign s    = cin ? s1 : s0;
    assign cout = cin ? c1[BLK] : c0[BLK];
endmodule

// File: rtl/pipe_csa_adder.sv
// pipe_csa_adder: NBLK-stage pipelined carry-select adder/subtractor; stage k
// resolves block k, with valid/ready flow control that freezes the whole pipe on stall.
module pipe_csa_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int NBLK = WIDTH / BLK;

    if (WIDTH % BLK != 0) begin : g_geom_err
        $error("pipe_csa_adder: WIDTH must be a multiple of BLK");
    end

    logic stall;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [WIDTH-1:0] xi, yi, xn;
        logic             vi, ci, oi, sc;
        logic [BLK-1:0]   s;
        // x holds resolved sum bits below block k and raw A bits above it
        logic [WIDTH-1:0] x, y;
        logic             v, c, o;
        if (k == 0) begin : g_in
            assign xi = A;
            assign yi = B;
            assign vi = in_valid;
            assign oi = op;
            assign ci = (op == OP_SUB) ? 1'b1 : Cin;
        end else begin : g_chain
            assign xi = g_stg[k-1].x;
            assign yi = g_stg[k-1].y;
            assign vi = g_stg[k-1].v;
            assign oi = g_stg[k-1].o;
            assign ci = g_stg[k-1].c;
        end
        csa_block #(.BLK(BLK)) u_blk (
            .a    (xi[k*BLK +: BLK]),
            .b    (yi[k*BLK +: BLK]),
            .op   (oi),
            .cin  (ci),
            .s    (s),
            .cout (sc)
        );
        always_comb begin
            xn = xi;
            xn[k*BLK +: BLK] = s;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x <= '0;
                y <= '0;
                v <= 1'b0;
                c <= 1'b0;
                o <= 1'b0;
            end else if (!stall) begin
                x <= xn;
                y <= yi;
                v <= vi;
                c <= sc;
                o <= oi;
            end
        end
    end

    logic ae, be, ovf_n, ovf_q;
    assign ae    = g_stg[NBLK-1].xi[WIDTH-1];
    assign be    = g_stg[NBLK-1].yi[WIDTH-1] ^ (g_stg[NBLK-1].oi == OP_SUB);
    assign ovf_n = (ae == be) && (g_stg[NBLK-1].s[BLK-1] != ae);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (!stall)
            ovf_q <= ovf_n;
    end

    logic unused_tail;
    assign unused_tail = ^{g_stg[NBLK-1].y, g_stg[NBLK-1].o};

    assign stall     = g_stg[NBLK-1].v && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = g_stg[NBLK-1].v;
    assign Sum       = g_stg[NBLK-1].x;
    assign Cout      = g_stg[NBLK-1].c;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_csa_adder.sv
// tb_pipe_csa_adder: directed and randomized checks of pipe_csa_adder against
// a plain-arithmetic model, for 32/8, 16/4 and 8/8 geometries.
module tb_pipe_csa_adder;
    import csa_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    logic        iv32 = 0, cin32 = 0, op32 = 0, or32 = 0;
    logic        ir32, ov32, co32, of32;
    logic [31:0] a32 = 0, b32 = 0, s32;
    logic        iv16 = 0, cin16 = 0, op16 = 0, or16 = 0;
    logic        ir16, ov16, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic        iv8 = 0, cin8 = 0, op8 = 0, or8 = 0;
    logic        ir8, ov8, co8, of8;
    logic [7:0]  a8 = 0, b8 = 0, s8;

    logic [33:0] q32[$];
    logic [33:0] q16[$];
    logic [33:0] q8[$];

    pipe_csa_adder #(.WIDTH(32), .BLK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .Cin(cin32), .op(op32), .out_valid(ov32), .out_ready(or32), .Sum(s32), .Cout(co32), .Ovf(of32));
    pipe_csa_adder #(.WIDTH(16), .BLK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .Cin(cin16), .op(op16), .out_valid(ov16), .out_ready(or16), .Sum(s16), .Cout(co16), .Ovf(of16));
    pipe_csa_adder #(.WIDTH(8), .BLK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .Cin(cin8), .op(op8), .out_valid(ov8), .out_ready(or8), .Sum(s8), .Cout(co8), .Ovf(of8));

    // {Ovf, Cout, Sum} from unsigned and signed integer arithmetic
    function automatic logic [33:0] model(input int w, input longint a, input longint b, input bit c, input bit o);
        longint half, full, sa, sb, sr;
        logic [33:0] r;
        half = longint'(1) << (w - 1);
        full = o ? a - b + (half << 1) : a + b + longint'(c);
        sa = (a >= half) ? a - (half << 1) : a;
        sb = (b >= half) ? b - (half << 1) : b;
        sr = o ? sa - sb : sa + sb + longint'(c);
        r = '0;
        r[31:0] = 32'(full & ((half << 1) - 1));
        r[32] = ((full >> w) & 1) != 0;
        r[33] = (sr < -half) || (sr >= half);
        return r;
    endfunction

    function automatic longint pick(input int w);
        longint m;
        int k;
        m = (longint'(1) << w) - 1;
        k = $urandom_range(0, 4);
        return (k == 0) ? 0 : (k == 1) ? m : (k == 2) ? (longint'(1) << (w - 1)) :
               (k == 3) ? (longint'(1) << (w - 1)) - 1 : (longint'($urandom) & m);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc32(input bit iv, input logic [31:0] a, input logic [31:0] b, input bit c, input bit o, input bit rdy);
        logic [33:0] e;
        @(negedge clk);
        iv32 = iv; a32 = a; b32 = b; cin32 = c; op32 = o; or32 = rdy;
        #1;
        if (ov32 && or32) begin
            if (q32.size() == 0) chk("u32 spurious result", q32.size(), 1);
            else begin
                e = q32.pop_front();
                chk("u32 Sum", s32, e[31:0]);
                chk("u32 Cout", co32, e[32]);
                chk("u32 Ovf", of32, e[33]);
            end
        end
        if (iv32 && ir32) q32.push_back(model(32, longint'(a), longint'(b), c, o));
    endtask

    task automatic cyc_small(input bit drain);
        logic [33:0] e;
        @(negedge clk);
        iv16 = drain ? 1'b0 : 1'($urandom); a16 = 16'(pick(16)); b16 = 16'(pick(16));
        cin16 = 1'($urandom); op16 = 1'($urandom); or16 = drain || ($urandom_range(0, 3) != 0);
        iv8 = drain ? 1'b0 : 1'($urandom); a8 = 8'(pick(8)); b8 = 8'(pick(8));
        cin8 = 1'($urandom); op8 = 1'($urandom); or8 = drain || ($urandom_range(0, 3) != 0);
        #1;
        if (ov16 && or16) begin
            if (q16.size() == 0) chk("u16 spurious result", q16.size(), 1);
            else begin
                e = q16.pop_front();
                chk("u16 Sum", s16, e[15:0]);
                chk("u16 Cout", co16, e[32]);
                chk("u16 Ovf", of16, e[33]);
            end
        end
        if (ov8 && or8) begin
            if (q8.size() == 0) chk("u8 spurious result", q8.size(), 1);
            else begin
                e = q8.pop_front();
                chk("u8 Sum", s8, e[7:0]);
                chk("u8 Cout", co8, e[32]);
                chk("u8 Ovf", of8, e[33]);
            end
        end
        if (iv16 && ir16) q16.push_back(model(16, longint'(a16), longint'(b16), cin16, op16));
        if (iv8 && ir8) q8.push_back(model(8, longint'(a8), longint'(b8), cin8, op8));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        logic [4:0]  pat;
        int          lat;
        #2;
        chk("reset out_valid", {ov32, ov16, ov8}, 3'b000);
        chk("reset Sum32", s32, 32'd0);
        chk("reset Sum16/8", {s16, s8}, 24'd0);
        chk("reset Cout/Ovf", {co32, of32, co16, of16, co8, of8}, 6'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready after reset", {ir32, ir16, ir8}, 3'b111);

        cyc32(1, 32'd8, 32'd9, 0, OP_ADD, 1);
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            cyc32(0, 0, 0, 0, OP_ADD, 1);
            if (ov32) begin
                lat = n;
                chk("u32 8+9 Sum", s32, 32'd17);
                chk("u32 8+9 Cout/Ovf", {co32, of32}, 2'b00);
            end
        end
        chk("u32 latency", lat, 4);

        cyc32(1, 32'd0, 32'd0, 0, OP_ADD, 1);
        cyc32(1, 32'd33, 32'd66, 1, OP_ADD, 1);
        cyc32(1, 32'hFFFF_FFFE, 32'd2, 0, OP_ADD, 1);
        pat = '0;
        for (int n = 0; n < 5; n++) begin
            cyc32(0, 0, 0, 0, OP_ADD, 1);
            pat = {pat[3:0], ov32};
        end
        chk("u32 stream spacing", pat, 5'b01110);

        cyc32(1, 32'd5, 32'd7, 0, OP_SUB, 1);
        cyc32(1, 32'd5, 32'd7, 1, OP_SUB, 1);
        cyc32(1, 32'h7FFF_FFFF, 32'd1, 0, OP_ADD, 1);
        cyc32(1, 32'h8000_0000, 32'h8000_0000, 0, OP_ADD, 1);
        cyc32(1, 32'd0, 32'h8000_0000, 0, OP_SUB, 1);
        for (int n = 0; n < 6; n++) cyc32(0, 0, 0, 0, OP_ADD, 1);
        chk("u32 drained after sub/ovf", q32.size(), 0);

        for (int n = 0; n < 4; n++) cyc32(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
        cyc32(1, 32'd123, 32'd456, 0, OP_ADD, 0);
        chk("u32 stall out_valid", ov32, 1'b1);
        chk("u32 stall in_ready", ir32, 1'b0);
        hold = s32;
        for (int n = 0; n < 2; n++) begin
            cyc32(1, 32'd123, 32'd456, 0, OP_ADD, 0);
            chk("u32 stall in_ready", ir32, 1'b0);
            chk("u32 stall Sum stable", s32, hold);
        end
        for (int n = 0; n < 8 && q32.size() > 0; n++) cyc32(0, 0, 0, 0, OP_ADD, 1);
        chk("u32 drained after stall", q32.size(), 0);

        cyc32(1, $urandom, $urandom, 0, OP_ADD, 1);
        cyc32(1, $urandom, $urandom, 0, OP_SUB, 1);
        cyc32(0, 0, 0, 0, OP_ADD, 0);
        cyc32(0, 0, 0, 0, OP_ADD, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("u32 out_valid in reset", ov32, 1'b0);
        chk("u32 Sum in reset", s32, 32'd0);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("u32 in_ready after re-reset", ir32, 1'b1);
        for (int n = 0; n < 6; n++) begin
            cyc32(0, 0, 0, 0, OP_ADD, 1);
            chk("u32 no stale result", ov32, 1'b0);
        end

        for (int n = 0; n < 600; n++) cyc_small(0);
        for (int n = 0; n < 12; n++) cyc_small(1);
        chk("u16 drained", q16.size(), 0);
        chk("u8 drained", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
